mgmt_rx_mac_filter: RTL and testbench



---
 rtl/mgmt_rx_mac_filter_pkg.sv | 30 +++
 rtl/mgmt_rx_delay_line.sv | 35 +++
 rtl/mgmt_rx_mac_filter.sv | 153 +++++++++++++++
 tb/tb_mgmt_rx_mac_filter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mgmt_rx_mac_filter_pkg.sv
// Shared types for the management RX destination-MAC filter: bus encoding,
// MAC address helpers and the filter state enumeration.
package mgmt_rx_mac_filter_pkg;

  typedef logic [47:0] mac_addr_t;

  localparam mac_addr_t MAC_BROADCAST = 48'hFFFF_FFFF_FFFF;

  typedef struct packed {
    logic        start;
    logic        data_valid;
    logic [31:0] data;
    logic [2:0]  bytes_valid;
    logic        commit;
    logic        drop;
  } EthernetRxBus;

  typedef enum logic [1:0] {
    FILT_IDLE    = 2'd0,
    FILT_HDR     = 2'd1,
    FILT_FWD     = 2'd2,
    FILT_DISCARD = 2'd3
  } mgmt_rx_filt_state_t;

  // Group (multicast) bit is the LSB of the first byte on the wire.
  function automatic logic mac_is_group(input mac_addr_t addr);
    return addr[40];
  endfunction

endpackage

// File: rtl/mgmt_rx_delay_line.sv
// Two-stage EthernetRxBus pipeline; the last stage is masked by gate_i and a
// one-cycle-registered drop can be injected onto the output.
module mgmt_rx_delay_line
  import mgmt_rx_mac_filter_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  EthernetRxBus bus_i,
  input  logic         gate_i,
  input  logic         inject_drop_i,
  output EthernetRxBus bus_o
);

  EthernetRxBus p0_q;
  EthernetRxBus p1_q;
  logic         inj_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p0_q  <= '0;
      p1_q  <= '0;
      inj_q <= 1'b0;
    end else begin
      p0_q  <= bus_i;
      p1_q  <= p0_q;
      inj_q <= inject_drop_i;
    end
  end

  always_comb begin
    bus_o      = gate_i ? p1_q : '0;
    bus_o.drop = bus_o.drop | inj_q;
  end

endmodule

// File: rtl/mgmt_rx_mac_filter.sv
// Destination-MAC filter between the management RX MAC and the RX frame FIFO.
// Define MGMT_RX_MULTICAST_EN to also accept group-addressed destinations.
module mgmt_rx_mac_filter
  import mgmt_rx_mac_filter_pkg::*;
#(
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  mac_addr_t              our_mac,
  input  logic                   promisc_en,
  input  EthernetRxBus           rx_bus_in,
  output EthernetRxBus           rx_bus_out,
  output logic [COUNT_WIDTH-1:0] accept_count,
  output logic [COUNT_WIDTH-1:0] drop_count,
  input  logic                   counters_clear
);

  mgmt_rx_filt_state_t    state_q, state_d;
  logic [31:0]            w0_q, w0_d;
  logic                   w0_vld_q, w0_vld_d;
  logic                   keep_p0_q, keep_p0_d, keep_p1_q, keep_p1_d;
  logic                   hdr_p0_q, hdr_p0_d, hdr_p1_q, hdr_p1_d;
  logic [COUNT_WIDTH-1:0] acc_cnt_q, acc_cnt_d, drp_cnt_q, drp_cnt_d;

  mac_addr_t dest;
  logic      start_in, end_in, mcast_ok, dest_ok;
  logic      decide, accept_now, runt, hdr_clr;
  logic      keep_in, hdr_in, gate, inject_drop;
  logic      acc_inc, drp_inc;

  function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
    return (&v) ? v : v + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
  endfunction

  // The decision uses the live word 1, so an accepted header's start can
  // leave the delay line in the same cycle without extra latency.
  always_comb begin
    start_in = rx_bus_in.start;
    end_in   = rx_bus_in.commit | rx_bus_in.drop;
    dest     = {w0_q, rx_bus_in.data[31:16]};
`ifdef MGMT_RX_MULTICAST_EN
    mcast_ok = mac_is_group(dest);
`else
    mcast_ok = 1'b0;
`endif
    dest_ok    = promisc_en | (dest == our_mac) | (dest == MAC_BROADCAST) | mcast_ok;
    decide     = (state_q == FILT_HDR) & w0_vld_q & rx_bus_in.data_valid & ~start_in & ~end_in;
    accept_now = decide & dest_ok;
    runt       = (state_q == FILT_HDR) & ~start_in & end_in;
  end

  always_comb begin
    state_d     = state_q;
    w0_d        = w0_q;
    w0_vld_d    = w0_vld_q;
    inject_drop = 1'b0;
    acc_inc     = 1'b0;
    drp_inc     = 1'b0;
    if (start_in) begin
      state_d     = FILT_HDR;
      w0_vld_d    = 1'b0;
      inject_drop = (state_q == FILT_FWD);
    end else begin
      case (state_q)
        FILT_HDR: begin
          if (runt) begin
            state_d = FILT_IDLE;
            drp_inc = 1'b1;
          end else if (decide) begin
            state_d = dest_ok ? FILT_FWD : FILT_DISCARD;
            drp_inc = ~dest_ok;
          end else if (rx_bus_in.data_valid && !w0_vld_q) begin
            w0_d     = rx_bus_in.data;
            w0_vld_d = 1'b1;
          end
        end
        FILT_FWD: begin
          if (end_in) begin
            state_d = FILT_IDLE;
            acc_inc = rx_bus_in.commit;
          end
        end
        FILT_DISCARD: begin
          if (end_in) state_d = FILT_IDLE;
        end
        default: state_d = state_q;
      endcase
    end
  end

  // Each delay-line slot carries a keep tag (forward it) and a hdr tag
  // (belongs to an undecided header, released only by an accept).
  always_comb begin
    hdr_clr   = decide | runt | start_in;
    keep_in   = ((state_q == FILT_FWD) & ~start_in) | accept_now;
    hdr_in    = start_in | ((state_q == FILT_HDR) & ~decide & ~end_in);
    keep_p0_d = keep_in;
    hdr_p0_d  = hdr_in & ~keep_in;
    keep_p1_d = keep_p0_q | (hdr_p0_q & accept_now);
    hdr_p1_d  = hdr_p0_q & ~hdr_clr;
    gate      = keep_p1_q | (hdr_p1_q & accept_now);
  end

  always_comb begin
    acc_cnt_d = acc_cnt_q;
    drp_cnt_d = drp_cnt_q;
    if (counters_clear) begin
      acc_cnt_d = '0;
      drp_cnt_d = '0;
    end else begin
      if (acc_inc) acc_cnt_d = sat_inc(acc_cnt_q);
      if (drp_inc) drp_cnt_d = sat_inc(drp_cnt_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FILT_IDLE;
      w0_q      <= '0;
      w0_vld_q  <= 1'b0;
      keep_p0_q <= 1'b0;
      keep_p1_q <= 1'b0;
      hdr_p0_q  <= 1'b0;
      hdr_p1_q  <= 1'b0;
      acc_cnt_q <= '0;
      drp_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      w0_q      <= w0_d;
      w0_vld_q  <= w0_vld_d;
      keep_p0_q <= keep_p0_d;
      keep_p1_q <= keep_p1_d;
      hdr_p0_q  <= hdr_p0_d;
      hdr_p1_q  <= hdr_p1_d;
      acc_cnt_q <= acc_cnt_d;
      drp_cnt_q <= drp_cnt_d;
    end
  end

  assign accept_count = acc_cnt_q;
  assign drop_count   = drp_cnt_q;

  mgmt_rx_delay_line u_delay (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus_i         (rx_bus_in),
    .gate_i        (gate),
    .inject_drop_i (inject_drop),
    .bus_o         (rx_bus_out)
  );

endmodule

// File: tb/tb_mgmt_rx_mac_filter.sv
// Randomized self-checking bench for mgmt_rx_mac_filter against a frame-level
// reference model; a COUNT_WIDTH=2 instance exercises counter saturation.
module tb_mgmt_rx_mac_filter;
  import mgmt_rx_mac_filter_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  mac_addr_t    our_mac;
  logic         promisc_en;
  logic         counters_clear;
  EthernetRxBus rx_in;
  EthernetRxBus rx_out;
  EthernetRxBus rx_out_sat;
  logic [15:0]  acc_cnt, drp_cnt;
  logic [1:0]   acc_sat, drp_sat;

  always #5 clk = ~clk;

  mgmt_rx_mac_filter #(.COUNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .our_mac(our_mac), .promisc_en(promisc_en),
    .rx_bus_in(rx_in), .rx_bus_out(rx_out), .accept_count(acc_cnt),
    .drop_count(drp_cnt), .counters_clear(counters_clear)
  );

  mgmt_rx_mac_filter #(.COUNT_WIDTH(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .our_mac(our_mac), .promisc_en(promisc_en),
    .rx_bus_in(rx_in), .rx_bus_out(rx_out_sat), .accept_count(acc_sat),
    .drop_count(drp_sat), .counters_clear(counters_clear)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit mon_en   = 1'b0;
  bit fwd_open = 1'b0;
  int m_acc = 0, m_drp = 0, m_acc_s = 0, m_drp_s = 0;
  EthernetRxBus exp_q [int];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : monitor
    EthernetRxBus e;
    if (mon_en) begin
      e = exp_q.exists(cyc) ? exp_q[cyc] : '0;
      check_eq("rx_bus_out", 64'(rx_out), 64'(e));
      check_eq("rx_bus_out_w2", 64'(rx_out_sat), 64'(e));
      if (exp_q.exists(cyc)) exp_q.delete(cyc);
    end
  end

  function automatic void add_exp(input int c, input EthernetRxBus ev);
    EthernetRxBus t;
    t = exp_q.exists(c) ? exp_q[c] : '0;
    t = t | ev;
    exp_q[c] = t;
  endfunction

  function automatic bit model_accept(input mac_addr_t d);
    bit a;
    a = promisc_en || (d == our_mac) || (d == 48'hFFFF_FFFF_FFFF);
`ifdef MGMT_RX_MULTICAST_EN
    a = a || d[40];
`endif
    return a;
  endfunction

  function automatic void bump_drop();
    if (m_drp < 65535) m_drp++;
    if (m_drp_s < 3) m_drp_s++;
  endfunction

  function automatic void bump_acc();
    if (m_acc < 65535) m_acc++;
    if (m_acc_s < 3) m_acc_s++;
  endfunction

  function automatic void clear_model();
    m_acc = 0; m_drp = 0; m_acc_s = 0; m_drp_s = 0;
  endfunction

  // One input cycle; events of forwarded frames are expected 2 cycles later.
  task automatic drive(input EthernetRxBus ev, input bit fwd, input bit clr, output int c);
    @(posedge clk); #1;
    rx_in          = ev;
    counters_clear = clr;
    c              = cyc;
    if (fwd) add_exp(c + 2, ev);
  endtask

  task automatic idle(input int n);
    int c;
    for (int i = 0; i < n; i++) drive('0, 1'b0, 1'b0, c);
  endtask

  task automatic check_counts(input string tag);
    check_eq({tag, "_accept_count"}, 64'(acc_cnt), 64'(m_acc));
    check_eq({tag, "_drop_count"}, 64'(drp_cnt), 64'(m_drp));
    check_eq({tag, "_accept_count_w2"}, 64'(acc_sat), 64'(m_acc_s));
    check_eq({tag, "_drop_count_w2"}, 64'(drp_sat), 64'(m_drp_s));
  endtask

  // term: 0 commit, 1 drop, 2 left open so the next start interrupts it.
  task automatic send_frame(input string tag, input mac_addr_t dest, input int nwords,
                            input int term, input bit clr, input int gapmax);
    EthernetRxBus ev, dev;
    int  c;
    bit  acc;
    acc = (nwords >= 2) && model_accept(dest);
    ev = '0;
    ev.start = 1'b1;
    drive(ev, acc, 1'b0, c);
    if (fwd_open) begin
      dev = '0;
      dev.drop = 1'b1;
      add_exp(c + 1, dev);
      fwd_open = 1'b0;
    end
    for (int i = 0; i < nwords; i++) begin
      if (i >= 2) idle($urandom_range(0, gapmax));
      ev = '0;
      ev.data_valid  = 1'b1;
      ev.bytes_valid = 3'($urandom_range(1, 4));
      if (i == 0)      ev.data = dest[47:16];
      else if (i == 1) ev.data = {dest[15:0], 16'($urandom)};
      else             ev.data = $urandom;
      drive(ev, acc, 1'b0, c);
      if (i == 1 && !acc) bump_drop();
    end
    if (term == 2) begin
      fwd_open = acc;
      return;
    end
    if (nwords >= 2) idle($urandom_range(0, gapmax));
    ev = '0;
    if (term == 0) ev.commit = 1'b1;
    else           ev.drop = 1'b1;
    drive(ev, acc, clr, c);
    if (clr)                      clear_model();
    else if (nwords < 2)          bump_drop();
    else if (acc && term == 0)    bump_acc();
    idle(3);
    check_counts(tag);
  endtask

  task automatic clear_pulse();
    int c;
    drive('0, 1'b0, 1'b1, c);
    clear_model();
    idle(2);
    check_counts("clear");
  endtask

  task automatic reset_mid_frame();
    EthernetRxBus ev;
    int c;
    ev = '0;
    ev.start = 1'b1;
    drive(ev, 1'b1, 1'b0, c);
    for (int i = 0; i < 4; i++) begin
      ev = '0;
      ev.data_valid  = 1'b1;
      ev.bytes_valid = 3'd4;
      ev.data = (i == 0) ? our_mac[47:16] : (i == 1) ? {our_mac[15:0], 16'h1234} : $urandom;
      drive(ev, 1'b1, 1'b0, c);
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    rx_in = '0;
    for (int k = cyc; k < cyc + 4; k++) if (exp_q.exists(k)) exp_q.delete(k);
    clear_model();
    fwd_open = 1'b0;
    #1;
    check_eq("rst_mid_bus_out", 64'(rx_out), 64'd0);
    check_counts("rst_mid");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    mac_addr_t d;
    int        nw, term, r, bi;
    our_mac        = 48'h02_00_00_00_00_01;
    promisc_en     = 1'b0;
    counters_clear = 1'b0;
    rx_in          = '0;
    #1 rst_n = 1'b0;
    mon_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_bus_out", 64'(rx_out), 64'd0);
    check_counts("reset");
    rst_n = 1'b1;
    idle(2);

    send_frame("own_16w", our_mac, 16, 0, 1'b0, 0);
    send_frame("other_uc", 48'h02_00_00_00_00_02, 6, 0, 1'b0, 1);
    promisc_en = 1'b1;
    send_frame("promisc", 48'h02_00_00_00_00_02, 6, 0, 1'b0, 1);
    promisc_en = 1'b0;
    send_frame("mcast", 48'h01_00_5E_00_00_FB, 8, 0, 1'b0, 2);
    send_frame("bcast", 48'hFF_FF_FF_FF_FF_FF, 5, 0, 1'b0, 2);
    send_frame("runt1", our_mac, 1, 0, 1'b0, 0);
    send_frame("runt0", our_mac, 0, 1, 1'b0, 0);
    send_frame("fwd_drop", our_mac, 4, 1, 1'b0, 1);
    send_frame("interrupted", our_mac, 7, 2, 1'b0, 0);
    send_frame("after_int", our_mac, 10, 0, 1'b0, 1);

    clear_pulse();
    for (int i = 0; i < 5; i++) send_frame("saturate", 48'h02_00_00_00_00_02, 3, 0, 1'b0, 0);
    send_frame("clr_commit", our_mac, 4, 0, 1'b1, 0);

    reset_mid_frame();
    send_frame("after_rst", our_mac, 6, 0, 1'b0, 1);

    for (int f = 0; f < 60; f++) begin
      d[47:16] = $urandom;
      d[15:0]  = 16'($urandom);
      r = $urandom_range(0, 4);
      case (r)
        0: d = our_mac;
        1: d = 48'hFF_FF_FF_FF_FF_FF;
        2: d[40] = 1'b1;
        3: d[40] = 1'b0;
        default: begin
          d  = our_mac;
          bi = $urandom_range(0, 47);
          d[bi] = ~d[bi];
        end
      endcase
      nw = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 1) : $urandom_range(2, 14);
      r  = $urandom_range(0, 9);
      term = (r < 6) ? 0 : (r < 8) ? 1 : 2;
      if (term == 2 && (nw < 2 || f == 59)) term = 0;
      promisc_en = ($urandom_range(0, 4) == 0);
      send_frame("rand", d, nw, term, ($urandom_range(0, 14) == 0), 2);
    end

    idle(4);
    check_eq("exp_drained", 64'(exp_q.num()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
